// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared launch FSM encodings and default depth for uart_tx_fifo
package uart_tx_fifo_pkg;

    localparam int TXQ_DEPTH_LOG2_DEFAULT = 4;

    typedef enum logic [1:0] {
        TXQ_IDLE    = 2'd0,
        TXQ_WAIT_HI = 2'd1,
        TXQ_WAIT_LO = 2'd2
    } txq_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer-side and transmitter-side signals of uart_tx_fifo
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT
) ();

    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  tx_bsy;
    logic                  send_trig;
    logic [7:0]            send_data;

    modport slave (
        input  wr_en, wr_data, tx_bsy,
        output full, empty, level, overflow, send_trig, send_data
    );

    modport master (
        output wr_en, wr_data, tx_bsy,
        input  full, empty, level, overflow, send_trig, send_data
    );

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - byte storage array, registered write and asynchronous read
module uart_tx_fifo_mem #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    // Contents are not reset; only the pointers define which entries are valid.
    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte queue and launch controller for m_uart_tx; UART_TX_FIFO_OVF_CNT_EN adds ovf_cnt
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_fifo_if.slave     bus
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_cnt
`endif
);

    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);

    txq_state_e              state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    send_trig_q;
    logic [7:0]              send_data_q;
    logic                    overflow_q;
    logic [7:0]              head_byte;
    logic                    full, empty, wr_accept, pop;

    assign full      = (level_q == DEPTH_LVL);
    assign empty     = (level_q == '0);
    // A write in a full cycle is dropped even if a pop frees a slot on the same edge.
    assign wr_accept = bus.wr_en && !full;

    uart_tx_fifo_mem #(.ADDR_W(DEPTH_LOG2)) u_mem (
        .clk     (clk),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_byte)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            TXQ_IDLE: begin
                if (!empty && !bus.tx_bsy) begin
                    pop     = 1'b1;
                    state_d = TXQ_WAIT_HI;
                end
            end
            TXQ_WAIT_HI: if (bus.tx_bsy)  state_d = TXQ_WAIT_LO;
            TXQ_WAIT_LO: if (!bus.tx_bsy) state_d = TXQ_IDLE;
            default:     state_d = TXQ_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (wr_accept && !pop) begin
            level_d = level_q + (DEPTH_LOG2 + 1)'(1);
        end else if (pop && !wr_accept) begin
            level_d = level_q - (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TXQ_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            send_trig_q <= 1'b0;
            send_data_q <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            send_trig_q <= pop;
            overflow_q  <= bus.wr_en && full;
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            // send_data only moves on a pop so it stays stable for the whole frame.
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + DEPTH_LOG2'(1);
                send_data_q <= head_byte;
            end
        end
    end

`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= 16'h0000;
        end else if (bus.wr_en && full && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
    assign bus.send_trig = send_trig_q;
    assign bus.send_data = send_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a behavioural transmitter
module tb_uart_tx_fifo;

    localparam int FRAME = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH_LOG2(4)) bus ();

`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef UART_TX_FIFO_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] sb_q[$];
    int         cyc = 0;
    bit         force_bsy = 1'b0;
    bit         trig_seen = 1'b0;
    int         remaining = 0;
    int         trig_count = 0;
    int         last_fall_cyc = -1;
    int         last_trig_cyc = -1;
    bit         check_gap = 1'b0;
    logic [7:0] last_byte = 8'h00;
    logic       prev_bsy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transmitter stand-in: busy rises one cycle after send_trig and lasts FRAME cycles.
    initial begin
        bus.tx_bsy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (force_bsy) begin
                bus.tx_bsy = 1'b1;
            end else if (trig_seen) begin
                trig_seen  = 1'b0;
                remaining  = FRAME;
                bus.tx_bsy = 1'b1;
            end else if (remaining > 0) begin
                remaining--;
                bus.tx_bsy = (remaining != 0);
            end else begin
                bus.tx_bsy = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_bsy && !bus.tx_bsy) begin
                chk("data_stable", bus.send_data, last_byte);
                last_fall_cyc = cyc;
            end
            prev_bsy = bus.tx_bsy;
            if (bus.send_trig) begin
                trig_seen = 1'b1;
                trig_count++;
                if (sb_q.size() == 0) begin
                    chk("trig_unexpected", 1, 0);
                end else begin
                    exp_b = sb_q.pop_front();
                    chk("send_data", bus.send_data, exp_b);
                end
                last_byte = bus.send_data;
                if (check_gap && last_fall_cyc > last_trig_cyc)
                    chk("launch_gap", cyc - last_fall_cyc, 2);
                last_trig_cyc = cyc;
            end
        end
    end

    task automatic wr(input logic [7:0] b, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (accept) sb_q.push_back(b);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n = 0;
        while ((sb_q.size() != 0 || bus.tx_bsy || !bus.empty || bus.send_trig) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < limit, 1);
    endtask

    initial begin
        int t0;
        int n;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_level", bus.level, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_trig", bus.send_trig, 0);
        chk("rst_data", bus.send_data, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single byte
        wr(8'hA5, 1'b1);
        chk("single_level", bus.level, 1);
        chk("single_nempty", bus.empty, 0);
        @(negedge clk);
        chk("single_trig", bus.send_trig, 1);
        chk("single_data", bus.send_data, 8'hA5);
        chk("single_empty", bus.empty, 1);
        wait_drain(200, "single_drain");

        // burst of three with launch spacing
        t0 = trig_count;
        last_fall_cyc = -1;
        check_gap = 1'b1;
        wr(8'h01, 1'b1);
        wr(8'h02, 1'b1);
        wr(8'h03, 1'b1);
        wait_drain(300, "burst_drain");
        check_gap = 1'b0;
        chk("burst_trigs", trig_count - t0, 3);

        // fill while transmitter is held busy
        force_bsy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i), 1'b1);
        chk("fill_level", bus.level, 16);
        chk("fill_full", bus.full, 1);
        chk("fill_noovf", bus.overflow, 0);
        wr(8'hEE, 1'b0);
        chk("ovf_pulse", bus.overflow, 1);
        chk("ovf_level", bus.level, 16);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        chk("ovf_cnt1", ovf_cnt, 1);
`endif
        @(negedge clk);
        chk("ovf_clear", bus.overflow, 0);

        // write and pop on the same edge while full
        force_bsy = 1'b0;
        @(negedge clk);
        wr(8'hDD, 1'b0);
        chk("simul_ovf", bus.overflow, 1);
        chk("simul_level", bus.level, 15);
        chk("simul_trig", bus.send_trig, 1);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        chk("ovf_cnt2", ovf_cnt, 2);
`endif
        wait_drain(1000, "fill_drain");

        // pointer wrap over 40 bytes
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (bus.full && n < 500) begin
                @(negedge clk);
                n++;
            end
            wr(8'(i), 1'b1);
        end
        wait_drain(2000, "wrap_drain");
        chk("wrap_level", bus.level, 0);
        chk("wrap_empty", bus.empty, 1);

        // asynchronous reset while in WAIT_LO with five queued
        for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i), 1'b1);
        n = 0;
        while (!bus.tx_bsy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_bsy_seen", n < 50, 1);
        @(negedge clk);
        chk("pre_rst_level", bus.level, 5);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        last_byte = 8'h00;
        #1;
        chk("arst_trig", bus.send_trig, 0);
        chk("arst_level", bus.level, 0);
        chk("arst_empty", bus.empty, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t0 = trig_count;
        repeat (30) @(negedge clk);
        chk("no_trig_after_rst", trig_count, t0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
